// File: rtl/match_sequencer.sv
// Round/match controller for the tug-of-war game: launches rounds, gates play, holds results, keeps score.
// Optional build macro ADAPTIVE_DIFF_EN lowers the cyber threshold by DIFF_STEP per player-1 point.
module match_sequencer #(
  parameter  int unsigned WIN_SCORE   = 7,
  parameter  int unsigned HOLD_CYCLES = 8,
  parameter  int unsigned DIFF_STEP   = 32,
  localparam int unsigned SCW         = $clog2(WIN_SCORE + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           win1,
  input  logic           win2,
  input  logic [8:0]     base_level,
  output logic           play_en,
  output logic           field_reset,
  output logic [SCW-1:0] score1,
  output logic [SCW-1:0] score2,
  output logic [8:0]     cyber_level,
  output logic           match_over,
  output logic [1:0]     winner
);

  localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SCW-1:0] WIN_VAL  = SCW'(WIN_SCORE);
  localparam logic [HCW-1:0] HOLD_END = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_PLAY,
    S_HOLD,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SCW-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [8:0]     cyber_level_q, cyber_level_d;
  logic           play_en_q, play_en_d;
  logic           field_reset_q, field_reset_d;
  logic           match_over_q, match_over_d;
  logic [1:0]     winner_q, winner_d;
  logic           start_q;
  logic           start_rise;
  logic [8:0]     launch_level;

  assign start_rise = start & ~start_q;

`ifdef ADAPTIVE_DIFF_EN
  logic [12:0] penalty;
  always_comb begin
    penalty      = 13'(DIFF_STEP) * 13'(score1_q);
    launch_level = ({4'b0, base_level} > penalty) ? 9'({4'b0, base_level} - penalty) : '0;
  end
`else
  assign launch_level = base_level;
`endif

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    score1_d      = score1_q;
    score2_d      = score2_q;
    cyber_level_d = cyber_level_q;
    match_over_d  = match_over_q;
    winner_d      = winner_q;

    case (state_q)
      S_IDLE: if (start_rise) state_d = S_LAUNCH;
      S_LAUNCH: begin
        cyber_level_d = launch_level;
        state_d       = S_PLAY;
      end
      S_PLAY: begin
        hold_cnt_d = '0;
        if (win1 && win2) begin
          state_d = S_HOLD;
        end else if (win1) begin
          score1_d = score1_q + 1'b1;
          if (score1_d == WIN_VAL) begin
            state_d      = S_DONE;
            match_over_d = 1'b1;
            winner_d     = 2'b01;
          end else begin
            state_d = S_HOLD;
          end
        end else if (win2) begin
          score2_d = score2_q + 1'b1;
          if (score2_d == WIN_VAL) begin
            state_d      = S_DONE;
            match_over_d = 1'b1;
            winner_d     = 2'b10;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_END) state_d = S_LAUNCH;
        else                        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      S_DONE: begin
        if (start_rise) begin
          score1_d     = '0;
          score2_d     = '0;
          match_over_d = 1'b0;
          winner_d     = 2'b00;
          state_d      = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Gating outputs are decoded from the next state so they stay registered yet track the FSM.
    play_en_d     = (state_d == S_PLAY);
    field_reset_d = (state_d == S_IDLE) || (state_d == S_LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      score1_q      <= '0;
      score2_q      <= '0;
      cyber_level_q <= '0;
      play_en_q     <= 1'b0;
      field_reset_q <= 1'b1;
      match_over_q  <= 1'b0;
      winner_q      <= 2'b00;
      start_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      cyber_level_q <= cyber_level_d;
      play_en_q     <= play_en_d;
      field_reset_q <= field_reset_d;
      match_over_q  <= match_over_d;
      winner_q      <= winner_d;
      start_q       <= start;
    end
  end

  assign play_en     = play_en_q;
  assign field_reset = field_reset_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign cyber_level = cyber_level_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule
